pdp11_fetch_unit: RTL and testbench

Instruction fetch stage of the PDP-11 pipeline: owns the fetch program counter (R7 view), issues word reads to the instruction flash, and buffers returned words in a small prefetch queue. The decode stage consumes `{instr, instr_pc}` over a valid/ready handshake. Branch redirects from the decode/execute path flush the queue and discard any in-flight read. The halt request stalls new fetches.

---
 rtl/pdp11_fetch_unit_pkg.sv | 18 +
 rtl/pdp11_prefetch_queue.sv | 57 +++++
 rtl/pdp11_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pdp11_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp11_fetch_unit_pkg.sv
// PDP-11 fetch stage shared types.
// Queue entry pairs a fetched word with its byte address.
package pdp11_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN,
    FETCH_HALT,
    FETCH_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } fetch_entry_t;

  localparam logic [15:0] PC_STEP = 16'd2;

endpackage

// File: rtl/pdp11_prefetch_queue.sv
// Prefetch FIFO of fetch entries.
// Synchronous flush wins over push/pop in the same cycle.
module pdp11_prefetch_queue
  import pdp11_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= entry_i;
        wr_q        <= inc(wr_q);
      end
      if (pop_i)
        rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/pdp11_fetch_unit.sv
// PDP-11 instruction fetch: PC, flash read issue,
// in-flight kill tracking and prefetch queue.
module pdp11_fetch_unit
  import pdp11_fetch_unit_pkg::*;
#(
  parameter int          FLASH_ADDR_W = 12,
  parameter int          QUEUE_DEPTH  = 2,
  parameter logic [15:0] RESET_PC     = 16'o000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    flash_rd,
  output logic [FLASH_ADDR_W-1:0] flash_addr,
  input  logic [15:0]             flash_rdata,
  input  logic                    redirect,
  input  logic [15:0]             redirect_pc,
  input  logic                    halt,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [15:0]             instr,
  output logic [15:0]             instr_pc,
  output logic [15:0]             fetch_pc,
  output logic                    odd_pc_err
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   inf_pc_q;
  logic          inflight_q;
  logic          err_q, err_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  ret;
  logic          pop;
  logic          push;
  logic          issue;
  logic          odd_redir;
  logic [CW:0]   committed;

  assign odd_redir = redirect & redirect_pc[0];
  assign instr_valid = (count != '0);
  assign pop = instr_valid & instr_ready;
  assign push = inflight_q & ~redirect;

  // Queued plus in-flight words, less the one leaving now.
  assign committed = {1'b0, count}
                   + (CW+1)'(inflight_q)
                   - (CW+1)'(pop);

  assign issue = reset_n
               & (state_q == FETCH_RUN)
               & ~halt
               & ~redirect
               & (committed < (CW+1)'(QUEUE_DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    unique case (state_q)
      FETCH_RUN:   if (halt) state_d = FETCH_HALT;
      FETCH_HALT:  if (!halt) state_d = FETCH_RUN;
      FETCH_FAULT: state_d = FETCH_FAULT;
      default:     state_d = FETCH_FAULT;
    endcase
    if (state_q != FETCH_FAULT) begin
      if (odd_redir) begin
        state_d = FETCH_FAULT;
        err_d   = 1'b1;
      end else if (redirect) begin
        pc_d = redirect_pc;
      end
    end
    if (issue)
      pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      inf_pc_q   <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      inflight_q <= issue;
      if (issue)
        inf_pc_q <= pc_q;
    end
  end

  assign ret.pc   = inf_pc_q;
  assign ret.word = flash_rdata;

  pdp11_prefetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (redirect),
    .push_i  (push),
    .entry_i (ret),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign flash_rd   = issue;
  assign flash_addr = pc_q[FLASH_ADDR_W:1];
  assign fetch_pc   = pc_q;
  assign instr      = head.word;
  assign instr_pc   = head.pc;
  assign odd_pc_err = err_q;

endmodule

// File: tb/tb_pdp11_fetch_unit.sv
// Bench for pdp11_fetch_unit: directed scenarios plus
// random traffic against a transaction-level model.
module tb_pdp11_fetch_unit;

  localparam int AW = 12;
  localparam int QD = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flash_rd;
  logic [AW-1:0] flash_addr;
  logic [15:0]   flash_rdata = '0;
  logic          redirect = 1'b0;
  logic [15:0]   redirect_pc = '0;
  logic          halt = 1'b0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [15:0]   instr;
  logic [15:0]   instr_pc;
  logic [15:0]   fetch_pc;
  logic          odd_pc_err;

  always #5 clk = ~clk;

  pdp11_fetch_unit #(
    .FLASH_ADDR_W (AW),
    .QUEUE_DEPTH  (QD),
    .RESET_PC     (16'o000000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flash_rd    (flash_rd),
    .flash_addr  (flash_addr),
    .flash_rdata (flash_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .fetch_pc    (fetch_pc),
    .odd_pc_err  (odd_pc_err)
  );

  logic [15:0] mem [0:(1<<AW)-1];

  always @(posedge clk)
    if (flash_rd) flash_rdata <= mem[flash_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Model: occ = words issued and neither delivered nor killed.
  int          occ;
  int          last_iss;
  logic [15:0] exp_pc;
  logic [15:0] iss_pc;
  bit          fault;
  bit          halt_prev;
  int          cyc;
  int          nrd;
  int          first_valid;

  task automatic model_reset();
    occ       = 0;
    last_iss  = 0;
    exp_pc    = 16'o000000;
    iss_pc    = 16'o000000;
    fault     = 1'b0;
    halt_prev = 1'b0;
  endtask

  task automatic tick();
    bit mv;
    bit pop;
    bit allow;
    @(negedge clk);
    if (!reset_n) begin
      model_reset();
      check("rst_rd", flash_rd, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_err", odd_pc_err, 0);
      check("rst_pc", fetch_pc, 0);
      check("rst_addr", flash_addr, 0);
    end else begin
      mv    = (occ - last_iss) > 0;
      pop   = mv && instr_ready;
      allow = !fault && !halt && !halt_prev && !redirect
              && (occ - int'(pop) < QD);
      check("valid", instr_valid, mv);
      if (pop) begin
        check("instr_pc", instr_pc, exp_pc);
        check("instr", instr, mem[exp_pc[AW:1]]);
        exp_pc += 16'd2;
      end
      check("flash_rd", flash_rd, allow);
      check("flash_addr", flash_addr, iss_pc[AW:1]);
      check("odd_err", odd_pc_err, fault);
      if (flash_rd) nrd++;
      if (instr_valid && first_valid < 0) first_valid = cyc;
      if (redirect) begin
        occ      = 0;
        last_iss = 0;
        if (redirect_pc[0]) fault = 1'b1;
        else if (!fault) begin
          iss_pc = redirect_pc;
          exp_pc = redirect_pc;
        end
      end else begin
        occ      = occ + int'(allow) - int'(pop);
        last_iss = int'(allow);
        if (allow) iss_pc += 16'd2;
      end
      halt_prev = halt;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("async_valid", instr_valid, 0);
    check("async_err", odd_pc_err, 0);
    tick();
    reset_n = 1'b1;
    cyc = 0;
    nrd = 0;
    first_valid = -1;
  endtask

  initial begin
    int n0;
    for (int i = 0; i < (1<<AW); i++)
      mem[i] = 16'($urandom);
    mem[0] = 16'o012700;
    mem[1] = 16'o000005;
    mem[2] = 16'o005200;
    model_reset();
    cyc = 0;
    nrd = 0;
    first_valid = -1;
    instr_ready = 1'b1;
    repeat (2) tick();

    // reset release, streaming
    do_reset();
    repeat (8) tick();
    check("first_valid_lat", first_valid, 2);

    // decode stall right after first valid
    do_reset();
    tick();
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_head_pc", instr_pc, 0);
      check("stall_head_w", instr, 16'o012700);
    end
    check("stall_reads", nrd, QD);
    instr_ready = 1'b1;
    repeat (6) tick();

    // redirect with read in flight and queue occupied
    redirect = 1'b1;
    redirect_pc = 16'o000100;
    n0 = cyc;
    tick();
    redirect = 1'b0;
    first_valid = -1;
    repeat (5) tick();
    check("redir_lat", first_valid - n0, 3);

    // redirect with full queue, decode stalled
    instr_ready = 1'b0;
    repeat (4) tick();
    redirect = 1'b1;
    redirect_pc = 16'o000200;
    tick();
    redirect = 1'b0;
    instr_ready = 1'b1;
    repeat (5) tick();

    // halt in steady state
    halt = 1'b1;
    nrd = 0;
    repeat (4) tick();
    check("halt_reads", nrd, 0);
    halt = 1'b0;
    repeat (6) tick();

    // PC wrap at top of address space
    redirect = 1'b1;
    redirect_pc = 16'o177776;
    tick();
    redirect = 1'b0;
    check("wrap_load", fetch_pc, 16'o177776);
    tick();
    check("wrap_pc", fetch_pc, 16'o000000);
    repeat (5) tick();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      tick();
    end
    redirect = 1'b0;
    halt = 1'b0;
    instr_ready = 1'b1;
    repeat (4) tick();

    // odd redirect target
    redirect = 1'b1;
    redirect_pc = 16'o000101;
    tick();
    redirect = 1'b0;
    nrd = 0;
    for (int i = 0; i < 20; i++) begin
      instr_ready = ($urandom_range(0, 1) != 0);
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      tick();
    end
    redirect = 1'b0;
    check("fault_err", odd_pc_err, 1);
    check("fault_valid", instr_valid, 0);
    check("fault_reads", nrd, 0);

    // reset clears the fault
    do_reset();
    instr_ready = 1'b1;
    repeat (6) tick();
    check("post_rst_err", odd_pc_err, 0);
    check("post_rst_lat", first_valid, 2);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
